// File: rtl/lcd_frame_sched_if.sv
// Bundles the command, pixel-source and serializer-byte signals of lcd_frame_sched.
// Latency: none; this only groups wires.
// Backpressure: the byte stream uses valid/ready; the cmd and pixel sides use a request plus a one-cycle ready pulse.
interface lcd_frame_sched_if;
  logic        enable;
  logic        cmd_valid;
  logic [8:0]  cmd_data;
  logic        cmd_ready;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic        pixel_ready;
  logic [11:0] pixel_hpos;
  logic [11:0] pixel_vpos;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_dc;
  logic        byte_last;
  logic        byte_ready;
  logic        frame_busy;
  logic        frame_done;

  // Scheduler side: owns the byte stream, the position and the status flags.
  modport master (
    input  enable, cmd_valid, cmd_data, pixel_valid, pixel_data, byte_ready,
    output cmd_ready, pixel_ready, pixel_hpos, pixel_vpos,
           byte_valid, byte_data, byte_dc, byte_last, frame_busy, frame_done
  );

  // Environment side: CPU command port, pixel source and serializer.
  modport slave (
    output enable, cmd_valid, cmd_data, pixel_valid, pixel_data, byte_ready,
    input  cmd_ready, pixel_ready, pixel_hpos, pixel_vpos,
           byte_valid, byte_data, byte_dc, byte_last, frame_busy, frame_done
  );
endinterface

// File: rtl/lcd_frame_sched.sv
// Arbitrates the SPI LCD byte serializer between CPU commands and the frame stream (window setup, then RGB565 pixels).
// Latency: a request is seen one cycle after cmd_valid/enable; bytes go back-to-back; each pixel adds one fetch cycle.
// Backpressure: all byte outputs are registered and held until byte_valid && byte_ready; pixel_valid low stalls the stream indefinitely.
module lcd_frame_sched #(
  parameter int H_DISP = 135,
  parameter int V_DISP = 240,
  parameter int X_OFS  = 52,
  parameter int Y_OFS  = 40
) (
  input  logic              clk,
  input  logic              rstn,
  lcd_frame_sched_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WIN,
    PIX_HI,
    PIX_LO
  } state_t;

  localparam logic [3:0]  WIN_LAST = 4'd10;
  localparam logic [15:0] X_FIRST  = 16'(X_OFS);
  localparam logic [15:0] X_END    = 16'(X_OFS + H_DISP - 1);
  localparam logic [15:0] Y_FIRST  = 16'(Y_OFS);
  localparam logic [15:0] Y_END    = 16'(Y_OFS + V_DISP - 1);
  localparam logic [11:0] H_LAST   = 12'(H_DISP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_DISP - 1);

  state_t      state;
  logic [3:0]  win_idx;
  logic [7:0]  pix_lo;

  logic        xfer;
  logic [8:0]  win_first;
  logic [8:0]  win_next;
  logic [15:0] rgb565;
  logic        unused_pix_bits;

  // Window setup sequence, returned as {dc, byte}: CASET + column range, RASET + row range, RAMWR.
  function automatic logic [8:0] win_byte(input logic [3:0] i);
    logic [8:0] b;
    b = {1'b0, 8'h2C};
    case (i)
      4'd0:    b = {1'b0, 8'h2A};
      4'd1:    b = {1'b1, X_FIRST[15:8]};
      4'd2:    b = {1'b1, X_FIRST[7:0]};
      4'd3:    b = {1'b1, X_END[15:8]};
      4'd4:    b = {1'b1, X_END[7:0]};
      4'd5:    b = {1'b0, 8'h2B};
      4'd6:    b = {1'b1, Y_FIRST[15:8]};
      4'd7:    b = {1'b1, Y_FIRST[7:0]};
      4'd8:    b = {1'b1, Y_END[15:8]};
      4'd9:    b = {1'b1, Y_END[7:0]};
      4'd10:   b = {1'b0, 8'h2C};
      default: b = {1'b0, 8'h2C};
    endcase
    return b;
  endfunction

  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign win_first = win_byte(4'd0);
  assign win_next  = win_byte(win_idx + 4'd1);

  // RGB888 -> RGB565 keeps the top 5/6/5 bits of each channel; the dropped low bits are collected here.
  assign rgb565          = {bus.pixel_data[23:19], bus.pixel_data[15:10], bus.pixel_data[7:3]};
  assign unused_pix_bits = ^{bus.pixel_data[18:16], bus.pixel_data[9:8], bus.pixel_data[2:0]};

  // Scheduler FSM: every output is a register, updated only on accept/transfer events.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      win_idx         <= 4'd0;
      pix_lo          <= 8'd0;
      bus.cmd_ready   <= 1'b0;
      bus.pixel_ready <= 1'b0;
      bus.pixel_hpos  <= 12'd0;
      bus.pixel_vpos  <= 12'd0;
      bus.byte_valid  <= 1'b0;
      bus.byte_data   <= 8'd0;
      bus.byte_dc     <= 1'b1;
      bus.byte_last   <= 1'b1;
      bus.frame_busy  <= 1'b0;
      bus.frame_done  <= 1'b0;
    end else begin
      // Handshake acknowledgements are single-cycle pulses.
      bus.cmd_ready   <= 1'b0;
      bus.pixel_ready <= 1'b0;
      bus.frame_done  <= 1'b0;

      case (state)
        IDLE: begin
          // Commands win over a pending frame; frames never interleave with commands.
          if (bus.cmd_valid) begin
            bus.cmd_ready  <= 1'b1;
            bus.byte_valid <= 1'b1;
            bus.byte_data  <= bus.cmd_data[7:0];
            bus.byte_dc    <= bus.cmd_data[8];
            bus.byte_last  <= 1'b1;
            state          <= CMD;
          end else if (bus.enable) begin
            win_idx        <= 4'd0;
            bus.frame_busy <= 1'b1;
            bus.byte_valid <= 1'b1;
            bus.byte_data  <= win_first[7:0];
            bus.byte_dc    <= win_first[8];
            bus.byte_last  <= 1'b1;
            state          <= WIN;
          end
        end

        CMD: begin
          if (xfer) begin
            bus.byte_valid <= 1'b0;
            state          <= IDLE;
          end
        end

        WIN: begin
          // Each window byte is its own CS frame; the next one is loaded on the transfer edge.
          if (xfer) begin
            if (win_idx == WIN_LAST) begin
              bus.byte_valid <= 1'b0;
              state          <= PIX_HI;
            end else begin
              win_idx       <= win_idx + 4'd1;
              bus.byte_data <= win_next[7:0];
              bus.byte_dc   <= win_next[8];
            end
          end
        end

        PIX_HI: begin
          // byte_valid low here means the pixel has not been fetched yet; wait for the source.
          if (!bus.byte_valid) begin
            if (bus.pixel_valid) begin
              bus.byte_valid <= 1'b1;
              bus.byte_data  <= rgb565[15:8];
              bus.byte_dc    <= 1'b1;
              bus.byte_last  <= 1'b0;
              pix_lo         <= rgb565[7:0];
            end
          end else if (xfer) begin
            bus.byte_data <= pix_lo;
            bus.byte_last <= 1'b1;
            state         <= PIX_LO;
          end
        end

        PIX_LO: begin
          // Pixel consumed: release it to the source and step the raster position.
          if (xfer) begin
            bus.byte_valid  <= 1'b0;
            bus.pixel_ready <= 1'b1;
            state           <= PIX_HI;
            if (bus.pixel_hpos == H_LAST) begin
              bus.pixel_hpos <= 12'd0;
              if (bus.pixel_vpos == V_LAST) begin
                bus.pixel_vpos <= 12'd0;
                bus.frame_done <= 1'b1;
                bus.frame_busy <= 1'b0;
                state          <= IDLE;
              end else begin
                bus.pixel_vpos <= bus.pixel_vpos + 12'd1;
              end
            end else begin
              bus.pixel_hpos <= bus.pixel_hpos + 12'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Bench for lcd_frame_sched: default-size instance for the literal window/pixel bytes, small instance for full frames.
// Latency: expectations are ordered byte queues, so timing freedom is allowed except where pulses are pinned.
// Backpressure: byte_ready and pixel_valid are throttled with $urandom; held bytes and the pixel gate are watched.
module tb_lcd_frame_sched;
  localparam int H1 = 5;
  localparam int V1 = 3;
  localparam int XO = 52;
  localparam int YO = 40;
  localparam int FRAME_BYTES = 11 + 2 * H1 * V1;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  lcd_frame_sched_if if0 ();
  lcd_frame_sched_if if1 ();

  lcd_frame_sched dut0 (.clk(clk), .rstn(rstn), .bus(if0.master));
  lcd_frame_sched #(.H_DISP(H1), .V_DISP(V1), .X_OFS(XO), .Y_OFS(YO))
    dut1 (.clk(clk), .rstn(rstn), .bus(if1.master));

  int checks = 0;
  int errors = 0;

  // Reference state: expected byte queue {is_pixel_hi, dc, last, data} and event counters.
  logic [23:0] pix_mem [V1][H1];
  logic [10:0] exp_q [$];
  int rdy_pct = 100;
  int pv_pct  = 100;
  int done_cnt = 0;
  int cr_cnt = 0;
  int frame_xfers = 0;
  int pix_cnt = 0;
  logic       prev_bv  = 1'b0;
  logic       prev_rdy = 1'b0;
  logic       prev_pv  = 1'b0;
  logic [9:0] prev_out = 10'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model565(input logic [23:0] p);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
  endfunction

  function automatic logic [10:0] ent(input bit hi, input bit dc, input bit last, input int d);
    return {hi, dc, last, 8'(d)};
  endfunction

  task automatic push_frame();
    int xe, ye, w;
    xe = XO + H1 - 1;
    ye = YO + V1 - 1;
    exp_q.push_back(ent(0, 0, 1, 'h2A));
    exp_q.push_back(ent(0, 1, 1, XO / 256));
    exp_q.push_back(ent(0, 1, 1, XO % 256));
    exp_q.push_back(ent(0, 1, 1, xe / 256));
    exp_q.push_back(ent(0, 1, 1, xe % 256));
    exp_q.push_back(ent(0, 0, 1, 'h2B));
    exp_q.push_back(ent(0, 1, 1, YO / 256));
    exp_q.push_back(ent(0, 1, 1, YO % 256));
    exp_q.push_back(ent(0, 1, 1, ye / 256));
    exp_q.push_back(ent(0, 1, 1, ye % 256));
    exp_q.push_back(ent(0, 0, 1, 'h2C));
    for (int v = 0; v < V1; v++) begin
      for (int h = 0; h < H1; h++) begin
        w = int'(model565(pix_mem[v][h]));
        exp_q.push_back(ent(1, 1, 0, w / 256));
        exp_q.push_back(ent(0, 1, 1, w % 256));
      end
    end
  endtask

  task automatic fill_pixels();
    for (int v = 0; v < V1; v++)
      for (int h = 0; h < H1; h++)
        pix_mem[v][h] = 24'($urandom);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_outs"},
          {if1.byte_valid, if1.byte_dc, if1.byte_last, if1.byte_data,
           if1.frame_busy, if1.frame_done, if1.cmd_ready, if1.pixel_ready},
          {1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    check({tag, "_pos"}, {if1.pixel_vpos, if1.pixel_hpos}, 24'd0);
  endtask

  // One clock of dut1: drive throttled inputs at the falling edge, then score what the DUT shows.
  task automatic step();
    logic [9:0]  cur;
    logic [10:0] e;
    int hp, vp;
    @(negedge clk);
    if1.byte_ready  = ($urandom_range(99) < rdy_pct);
    if1.pixel_valid = ($urandom_range(99) < pv_pct);
    hp = int'(if1.pixel_hpos);
    vp = int'(if1.pixel_vpos);
    if (hp < H1 && vp < V1) if1.pixel_data = pix_mem[vp][hp];
    if (if1.cmd_ready) if1.cmd_valid = 1'b0;

    cur = {if1.byte_dc, if1.byte_last, if1.byte_data};
    if (prev_bv && !prev_rdy) begin
      check("hold_valid", if1.byte_valid, 1);
      check("hold_byte", cur, prev_out);
    end
    if (!prev_bv && if1.byte_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      if (e[10]) check("pixel_gate", prev_pv, 1);
    end
    if (if1.byte_valid && if1.byte_ready) begin
      if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("byte", cur, e[9:0]);
      end
      if (if1.frame_busy) frame_xfers++;
    end
    if (if1.pixel_ready) begin
      pix_cnt++;
      check("hpos", if1.pixel_hpos, pix_cnt % H1);
      check("vpos", if1.pixel_vpos, (pix_cnt / H1) % V1);
      if (pix_cnt == H1 * V1) pix_cnt = 0;
    end
    if (if1.cmd_ready) begin
      cr_cnt++;
      check("cmd_rdy_busy", if1.frame_busy, 0);
    end
    if (if1.frame_done) begin
      done_cnt++;
      check("frame_len", frame_xfers, FRAME_BYTES);
      frame_xfers = 0;
    end
    prev_bv  = if1.byte_valid;
    prev_rdy = if1.byte_ready;
    prev_pv  = if1.pixel_valid;
    prev_out = cur;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    check("done_timeout", done_cnt, target);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (!if1.frame_busy && n < 200) begin
      step();
      n++;
    end
    check(tag, if1.frame_busy, 1);
  endtask

  initial begin
    logic [9:0] exp0 [13];
    logic [9:0] got0 [13];
    int k, n, pr0, cr0;

    if0.enable = 0; if0.cmd_valid = 0; if0.cmd_data = '0; if0.pixel_valid = 0;
    if0.pixel_data = '0; if0.byte_ready = 0;
    if1.enable = 0; if1.cmd_valid = 0; if1.cmd_data = '0; if1.pixel_valid = 0;
    if1.pixel_data = '0; if1.byte_ready = 0;

    #1 rstn = 1'b0;
    #1 check_reset("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Default-size instance: literal window bytes and the 0xFF8040 pixel.
    exp0 = '{10'h12A, 10'h300, 10'h334, 10'h300, 10'h3BA, 10'h12B, 10'h300,
             10'h328, 10'h301, 10'h317, 10'h12C, 10'h2FC, 10'h308};
    if0.enable = 1; if0.byte_ready = 1; if0.pixel_valid = 1; if0.pixel_data = 24'hFF8040;
    k = 0; n = 0; pr0 = 0;
    while (k < 13 && n < 300) begin
      @(negedge clk);
      n++;
      if (if0.pixel_ready) pr0++;
      if (if0.byte_valid && if0.byte_ready) begin
        got0[k] = {if0.byte_dc, if0.byte_last, if0.byte_data};
        k++;
      end
    end
    check("d0_count", k, 13);
    for (int i = 0; i < 13; i++) check($sformatf("d0_byte%0d", i), got0[i], exp0[i]);
    check("d0_prdy_early", pr0, 0);
    @(negedge clk);
    if0.byte_ready = 0; if0.enable = 0; if0.pixel_valid = 0;
    check("d0_prdy", if0.pixel_ready, 1);
    check("d0_pos", {if0.pixel_vpos, if0.pixel_hpos}, {12'd0, 12'd1});

    // Full frame, no throttling.
    fill_pixels();
    push_frame();
    if1.enable = 1;
    wait_done(1, 500);
    check("a_drain", exp_q.size(), 0);

    // Back-to-back frame with a command raised mid-frame; it must wait for frame_done.
    push_frame();
    exp_q.push_back(ent(0, 0, 1, 'h29));
    push_frame();
    repeat (15) step();
    check("b_busy", if1.frame_busy, 1);
    if1.cmd_valid = 1; if1.cmd_data = 9'h029;
    cr0 = cr_cnt;
    wait_done(2, 500);
    check("b_cmd_held", cr_cnt, cr0);

    // Third frame throttled; enable dropped mid-frame must not cut it short or start another.
    rdy_pct = 60; pv_pct = 50;
    wait_busy("c_start");
    check("c_cmd_once", cr_cnt, cr0 + 1);
    if1.enable = 0;
    wait_done(3, 4000);
    repeat (30) step();
    check("c_no_restart", {if1.frame_busy, if1.byte_valid}, 2'b00);
    check("c_drain", exp_q.size(), 0);

    // Command and enable in the same cycle from IDLE: command byte first.
    fill_pixels();
    exp_q.push_back(ent(0, 1, 1, 'hA5));
    push_frame();
    rdy_pct = 80; pv_pct = 80;
    cr0 = cr_cnt;
    if1.cmd_valid = 1; if1.cmd_data = 9'h1A5; if1.enable = 1;
    wait_busy("d_start");
    check("d_cmd_first", cr_cnt, cr0 + 1);
    if1.enable = 0;
    wait_done(4, 4000);
    check("d_drain", exp_q.size(), 0);

    // Reset while the low byte of pixel (2,1) is stalled.
    rdy_pct = 100; pv_pct = 100;
    push_frame();
    if1.enable = 1;
    n = 0;
    while (!(pix_cnt >= 7 && if1.byte_valid && !if1.byte_last) && n < 500) begin
      step();
      n++;
    end
    check("e_hi_seen", {if1.byte_valid, if1.byte_last}, 2'b10);
    rdy_pct = 0;
    step();
    step();
    check("e_lo_stall", {if1.byte_valid, if1.byte_last}, 2'b11);
    check("e_pre_pos", {if1.pixel_vpos, if1.pixel_hpos}, {12'd1, 12'd2});
    #2 rstn = 1'b0;
    #1 check_reset("e_reset");
    if1.enable = 0;
    exp_q.delete();
    frame_xfers = 0; pix_cnt = 0; prev_bv = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Restart after reset must begin again at 0x2A and pixel (0,0).
    fill_pixels();
    push_frame();
    rdy_pct = 70; pv_pct = 70;
    if1.enable = 1;
    wait_busy("f_start");
    if1.enable = 0;
    wait_done(5, 4000);
    check("f_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
